// File: rtl/alu_exec.sv
// alu_exec: 16-bit execute unit with logic/arithmetic/compare ops and
// optional one-bit-per-clock serial shifter.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; single-cycle ops complete from here
// ST_SHIFT | serial shift in progress, one bit position per clock
module alu_exec #(
  parameter int unsigned SERIAL_SHIFT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  aluOpcode,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  input  logic        carryIn,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] result,
  output logic        flagC,
  output logic        flagF,
  output logic        flagL,
  output logic        flagZ,
  output logic        flagN
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] result_q, result_d;
  logic [15:0] work_q, work_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        right_q, right_d;
  logic        arith_q, arith_d;
  logic        c_q, c_d, f_q, f_d, l_q, l_d, z_q, z_d, n_q, n_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;

  logic [4:0]  sh_amt;
  logic        sh_right;
  logic        sh_arith;
  logic [4:0]  sh_n;
  logic        add_cin;
  logic        sub_bin;
  logic [16:0] add_sum;
  logic [16:0] sub_diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic [15:0] barrel;
  logic [15:0] work_step;

  // Shift amount is a 5-bit two's complement value; negative means right.
  // The magnitude of -16 is 16, which still fits the 5-bit counter.
  assign sh_amt   = opB[4:0];
  assign sh_right = sh_amt[4];
  assign sh_n     = sh_right ? (5'd0 - sh_amt) : sh_amt;
  assign sh_arith = (aluOpcode == 8'h82) || (aluOpcode == 8'h83) || (aluOpcode == 8'h86);

  // Carry/borrow in only participates for the ADDC/SUBC opcodes.
  assign add_cin  = (aluOpcode == 8'h07) & carryIn;
  assign sub_bin  = (aluOpcode == 8'h0A) & carryIn;
  assign add_sum  = {1'b0, opA} + {1'b0, opB} + {16'd0, add_cin};
  assign sub_diff = {1'b0, opA} - {1'b0, opB} - {16'd0, sub_bin};
  assign add_ovf  = (opA[15] == opB[15]) && (add_sum[15] != opA[15]);
  assign sub_ovf  = (opA[15] != opB[15]) && (sub_diff[15] != opA[15]);

  // Single-cycle barrel shift, also used when the amount is zero.
  always_comb begin
    if (!sh_right)
      barrel = opA << sh_n;
    else if (sh_arith)
      barrel = 16'($signed(opA) >>> sh_n);
    else
      barrel = opA >> sh_n;
  end

  // One serial shift step on the latched work register.
  assign work_step = right_q ? {arith_q & work_q[15], work_q[15:1]}
                             : {work_q[14:0], 1'b0};

  // Next-state, decode and execute.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    right_d   = right_q;
    arith_d   = arith_q;
    c_d       = c_q;
    f_d       = f_q;
    l_d       = l_q;
    z_d       = z_q;
    n_d       = n_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          if (aluOpcode[7:4] == 4'hF) begin
            result_d = {opB[7:0], 8'h00};
          end else begin
            case (aluOpcode)
              8'h01: result_d = opA & opB;
              8'h02: result_d = opA | opB;
              8'h03: result_d = opA ^ opB;
              8'h05, 8'h07: begin
                result_d = add_sum[15:0];
                c_d      = add_sum[16];
                f_d      = add_ovf;
              end
              8'h06: result_d = add_sum[15:0];
              8'h09, 8'h0A: begin
                result_d = sub_diff[15:0];
                c_d      = sub_diff[16];
                f_d      = sub_ovf;
              end
              8'h0B: begin
                z_d = (opA == opB);
                l_d = (opA < opB);
                n_d = ($signed(opA) < $signed(opB));
              end
              8'h0D, 8'h4F: result_d = opB;
              8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h86: begin
                if ((SERIAL_SHIFT == 0) || (sh_n == 5'd0)) begin
                  result_d = barrel;
                end else begin
                  done_d  = 1'b0;
                  state_d = ST_SHIFT;
                  work_d  = opA;
                  cnt_d   = sh_n;
                  right_d = sh_right;
                  arith_d = sh_arith;
                end
              end
              default: illegal_d = 1'b1;
            endcase
          end
        end
      end
      ST_SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_d = work_step;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= 16'h0000;
      work_q    <= 16'h0000;
      cnt_q     <= 5'd0;
      right_q   <= 1'b0;
      arith_q   <= 1'b0;
      c_q       <= 1'b0;
      f_q       <= 1'b0;
      l_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      right_q   <= right_d;
      arith_q   <= arith_d;
      c_q       <= c_d;
      f_q       <= f_d;
      l_q       <= l_d;
      z_q       <= z_d;
      n_q       <= n_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy    = (state_q == ST_SHIFT);
  assign done    = done_q;
  assign illegal = illegal_q;
  assign result  = result_q;
  assign flagC   = c_q;
  assign flagF   = f_q;
  assign flagL   = l_q;
  assign flagZ   = z_q;
  assign flagN   = n_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed steps with a scoreboard of expected completions.
module tb_alu_exec;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  aluOpcode;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        carryIn;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [15:0] result;
  logic        flagC, flagF, flagL, flagZ, flagN;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [4:0]  flg;   // {C,F,L,Z,N}
    logic        ill;
    logic [7:0]  lat;   // edges after acceptance before done; also busy cycles
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  alu_exec #(.SERIAL_SHIFT(1)) dut (
    .clock(clock), .reset(reset), .start(start), .aluOpcode(aluOpcode),
    .opA(opA), .opB(opB), .carryIn(carryIn), .busy(busy), .done(done),
    .illegal(illegal), .result(result), .flagC(flagC), .flagF(flagF),
    .flagL(flagL), .flagZ(flagZ), .flagN(flagN)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input string tag, input logic [15:0] r,
                       input logic [4:0] f, input logic il, input int n, input bit push);
    exp_t e;
    aluOpcode = op; opA = a; opB = b; carryIn = ci; start = 1'b1;
    if (push) begin
      e.res = r; e.flg = f; e.ill = il; e.lat = 8'(n);
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit poke);
    exp_t  e;
    string t;
    int    lat = 0;
    int    bcnt = 0;
    bit    got = 0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    while (!got && lat < 40) begin
      if (done === 1'b1) begin
        got = 1;
      end else begin
        if (busy === 1'b1) bcnt++;
        if (poke && busy === 1'b1) begin
          start = 1'b1; aluOpcode = 8'h05;
          opA = 16'($urandom); opB = 16'($urandom); carryIn = 1'($urandom);
        end
        @(negedge clock);
        lat++;
      end
    end
    start = 1'b0;
    check({t, " done"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({t, " result"},  {16'd0, result}, {16'd0, e.res});
      check({t, " flags"},   {27'd0, flagC, flagF, flagL, flagZ, flagN}, {27'd0, e.flg});
      check({t, " illegal"}, {31'd0, illegal}, {31'd0, e.ill});
      check({t, " latency"}, 32'(lat), {24'd0, e.lat});
      check({t, " busy"},    32'(bcnt), {24'd0, e.lat});
    end
  endtask

  task automatic step(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input string tag, input logic [15:0] r,
                      input logic [4:0] f, input logic il, input int n, input bit poke);
    issue(op, a, b, ci, tag, r, f, il, n, 1'b1);
    wait_done(poke);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; aluOpcode = 8'h00; opA = 16'h0; opB = 16'h0; carryIn = 1'b0;
    repeat (2) @(negedge clock);
    check("reset result", {16'd0, result}, 32'h0);
    check("reset flags", {27'd0, flagC, flagF, flagL, flagZ, flagN}, 32'h0);
    check("reset busy/done/ill", {29'd0, busy, done, illegal}, 32'h0);
    reset = 1'b0;

    // first start right after reset release; back-to-back from here on
    step(8'h05, 16'h7FFF, 16'h0001, 1'b0, "add_ovf",  16'h8000, 5'b01000, 1'b0, 0, 0);
    step(8'h06, 16'h7FFF, 16'h0001, 1'b0, "addu",     16'h8000, 5'b01000, 1'b0, 0, 0);
    step(8'h07, 16'hFFFF, 16'h0000, 1'b1, "addc",     16'h0000, 5'b10000, 1'b0, 0, 0);
    step(8'h0A, 16'h0000, 16'h0000, 1'b1, "subc",     16'hFFFF, 5'b10000, 1'b0, 0, 0);
    step(8'h0B, 16'h0005, 16'hFFFF, 1'b0, "cmp_lt",   16'hFFFF, 5'b10100, 1'b0, 0, 0);
    step(8'h09, 16'h8000, 16'h0001, 1'b1, "sub_ovf",  16'h7FFF, 5'b01100, 1'b0, 0, 0);
    step(8'h0B, 16'h1234, 16'h1234, 1'b0, "cmp_eq",   16'h7FFF, 5'b01010, 1'b0, 0, 0);
    step(8'h01, 16'hF0F0, 16'h0FF0, 1'b0, "and",      16'h00F0, 5'b01010, 1'b0, 0, 0);
    step(8'h02, 16'hF000, 16'h000F, 1'b0, "or",       16'hF00F, 5'b01010, 1'b0, 0, 0);
    step(8'h03, 16'hFFFF, 16'h00FF, 1'b0, "xor",      16'hFF00, 5'b01010, 1'b0, 0, 0);
    step(8'h0D, 16'h1111, 16'hBEEF, 1'b0, "mov",      16'hBEEF, 5'b01010, 1'b0, 0, 0);
    step(8'h4F, 16'h2222, 16'h1357, 1'b0, "pass",     16'h1357, 5'b01010, 1'b0, 0, 0);
    step(8'h0F, 16'hFFFF, 16'h0001, 1'b1, "illegal",  16'h1357, 5'b01010, 1'b1, 0, 0);
    step(8'hF7, 16'h3333, 16'h00AB, 1'b0, "lui",      16'hAB00, 5'b01010, 1'b0, 0, 0);
    step(8'h86, 16'h8000, 16'h001C, 1'b0, "ashu_r4",  16'hF800, 5'b01010, 1'b0, 4, 1);
    step(8'h84, 16'h0001, 16'h000F, 1'b0, "lsh_l15",  16'h8000, 5'b01010, 1'b0, 15, 0);
    step(8'h84, 16'h1234, 16'h0000, 1'b0, "lsh_0",    16'h1234, 5'b01010, 1'b0, 0, 0);
    step(8'h80, 16'h8001, 16'h001F, 1'b0, "lshi_r1",  16'h4000, 5'b01010, 1'b0, 1, 0);
    step(8'h83, 16'h8000, 16'h0010, 1'b0, "ashui_r16",16'hFFFF, 5'b01010, 1'b0, 16, 1);
    step(8'h81, 16'h8000, 16'h0010, 1'b0, "lshi_r16", 16'h0000, 5'b01010, 1'b0, 16, 0);
    step(8'h82, 16'h8421, 16'h0004, 1'b0, "ashui_l4", 16'h4210, 5'b01010, 1'b0, 4, 0);
    step(8'h05, 16'hFFFF, 16'h0001, 1'b0, "add_carry",16'h0000, 5'b10010, 1'b0, 0, 0);
    step(8'h0B, 16'h8000, 16'h0001, 1'b0, "cmp_sgn",  16'h0000, 5'b10001, 1'b0, 0, 0);

    // done is a single-cycle pulse
    @(negedge clock);
    check("idle done/illegal", {30'd0, done, illegal}, 32'h0);

    // reset in the third cycle of a 10-position shift
    issue(8'h84, 16'h0001, 16'h000A, 1'b0, "lsh_abort", 16'h0, 5'b0, 1'b0, 10, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort result", {16'd0, result}, 32'h0);
    check("abort flags", {27'd0, flagC, flagF, flagL, flagZ, flagN}, 32'h0);
    check("abort busy/done/ill", {29'd0, busy, done, illegal}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    step(8'h05, 16'h0003, 16'h0004, 1'b0, "post_reset_add", 16'h0007, 5'b00000, 1'b0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      check("no stale done", {31'd0, done}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter SERIAL_SHIFT, default 1; 1 = shifts execute one bit position per clock, 0 = single-cycle barrel shift.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to execute; sampled only when busy = 0.
REQ-005 aluOpcode  input  8  operation code in controller encoding (REQ-010).
REQ-006 opA, opB  input  16 each  operands, latched on accepted start.
REQ-007 carryIn  input  1  carry/borrow in for ADDC/SUBC, latched on accepted start.
REQ-008 busy  output  1  high while a serial shift is in progress.
REQ-009 done  output  1  one-cycle pulse; result, flags and illegal valid while high; illegal  output  1  high with done for an unknown opcode; result  output  16  registered result; flagC, flagF, flagL, flagZ, flagN  output  1 each  registered status flags.

Function
REQ-010 Decode: 0x01 AND, 0x02 OR, 0x03 XOR, 0x05 ADD, 0x06 ADDU, 0x07 ADDC, 0x09 SUB, 0x0A SUBC, 0x0B CMP, 0x0D MOV (result = B), 0x4F pass (result = B), 0x80/0x81 LSHI, 0x84 LSH, 0x82/0x83 ASHUI, 0x86 ASHU, 0xF0-0xFF LUI (result = {B[7:0], 8'h00}); any other code is illegal.
REQ-011 Arithmetic modulo 2^16; ADDC = A+B+carryIn; SUB = A-B; SUBC = A-B-carryIn.
REQ-012 ADD, ADDC, SUB, SUBC update flagC (carry out for add, borrow for subtract) and flagF (signed overflow); no other op changes C or F.
REQ-013 CMP leaves result unchanged; sets flagZ = (A==B), flagL = (A<B unsigned), flagN = (A<B signed); no other op changes Z, L, N.
REQ-014 ADDU, logic ops, MOV, pass, LUI and shifts change no flags.
REQ-015 Shift amount = B[4:0] two's complement; positive = left, negative = right; LSH/LSHI right shifts zero-fill; ASHU/ASHUI right shifts replicate A[15]; left shifts zero-fill; amount -16 yields 0x0000 (logical) or 16 copies of A[15] (arithmetic).
REQ-016 FSM states IDLE and SHIFT; reset enters IDLE.
REQ-017 start accepted at edge E0 when in IDLE; non-shift op, illegal op, any shift with amount 0, or any shift when SERIAL_SHIFT = 0: result/flags updated at E0, done = 1 for the cycle after E0, FSM stays IDLE, busy stays 0.
REQ-018 Serial shift with |amount| = n > 0: at E0 load work register = A, counter = n, enter SHIFT, busy = 1; each following edge shifts one position and decrements; at edge En result written, done = 1 for one cycle, busy = 0, return to IDLE.
REQ-019 start while busy = 1 is ignored with no side effects; aluOpcode/opA/opB/carryIn changes during SHIFT do not affect the operation in progress.
REQ-020 start asserted during the done cycle is accepted (back-to-back, no dead cycle).
REQ-021 Illegal opcode: done = 1 and illegal = 1 for one cycle; result and all flags unchanged.
REQ-022 done and illegal are 0 in every cycle not specified above; result and flags hold between operations.

Reset
REQ-023 reset asserted: immediately result = 0x0000, all flags = 0, busy = 0, done = 0, illegal = 0, FSM = IDLE, counter = 0.
REQ-024 reset during SHIFT aborts the operation; no done pulse is produced for it after reset release.
REQ-025 First start is accepted at the first rising edge after reset deasserts.

Verification
REQ-026 ADD A=0x7FFF B=0x0001 -> next cycle done=1, result=0x8000, flagC=0, flagF=1; ADDU same operands -> result=0x8000, C/F unchanged.
REQ-027 SUBC A=0x0000 B=0x0000 carryIn=1 -> result=0xFFFF, flagC=1, flagF=0; CMP A=0x0005 B=0xFFFF -> result unchanged, Z=0, L=1, N=0.
REQ-028 SERIAL_SHIFT=1, ASHU A=0x8000 B=0x001C (-4) -> busy=1 four cycles, done at 4th edge, result=0xF800; start pulses mid-shift ignored.
REQ-029 LSH A=0x0001 B=0x000F -> result=0x8000 after 15 cycles (SERIAL_SHIFT=1) or next cycle (SERIAL_SHIFT=0); LSH B=0x0000 -> done next cycle, result=A.
REQ-030 aluOpcode=0x0F -> done=1, illegal=1, result and flags unchanged; LUI B=0x00AB -> result=0xAB00.
REQ-031 Reset asserted at 3rd cycle of a 10-position shift -> outputs zero immediately, no done after release; new ADD accepted on first post-reset edge.
